// File: rtl/add_round_key_stage.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_stage
// Description : AES AddRoundKey pipeline stage. XORs the column-mixed state
//               with the round key, tags every result with its round number
//               inside the block and flags round-sequence errors. A
//               valid/ready handshake sits on both sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NR         number of AES rounds per block (1..15)
// Build option
//   SKID_BUF_EN  defined   : output register plus one-entry skid register,
//                            in_ready comes straight from a flop
//                undefined : single output register, in_ready is
//                            !out_valid || out_ready
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    upstream beat present
//   in_ready   out  1    beat accepted this cycle when in_valid is high
//   state_in   in   128  mixColumns result, byte 0 at bits 0:7
//   round_key  in   128  round key, sampled with state_in
//   in_last    in   1    beat is the final round of its block
//   out_valid  out  1    result present on state_out
//   out_ready  in   1    downstream takes the result
//   state_out  out  128  state_in ^ round_key
//   out_last   out  1    in_last carried with the result
//   round_idx  out  4    round number of the result (1..NR)
//   err        out  1    sticky round-sequence error
// ============================================================================
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out,
  output logic         out_last,
  output logic [3:0]   round_idx,
  output logic         err
);

  localparam logic [3:0] c_last_round = 4'(NR);

  // --------------------------------------------------------------------------
  // Round tracking, shared by both buffer builds
  // --------------------------------------------------------------------------
  logic         w_accept;
  logic [3:0]   w_tag;
  logic         w_seq_err;
  logic [0:127] w_beat_data;

  logic [3:0]   rc_q, rc_d;
  logic         err_q, err_d;

  assign w_accept    = in_valid && in_ready;
  assign w_tag       = rc_q + 4'd1;
  assign w_beat_data = state_in ^ round_key;
  // A final beat must land exactly on round NR; a non-final beat reaching NR
  // means the block is running past its round budget.
  assign w_seq_err   = in_last ? (w_tag != c_last_round) : (w_tag == c_last_round);

  always_comb begin
    rc_d  = rc_q;
    err_d = err_q;
    if (w_accept) begin
      // Overrun wraps the counter so the following beat restarts at round 1.
      rc_d  = (in_last || (w_tag == c_last_round)) ? 4'd0 : w_tag;
      err_d = err_q | w_seq_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q  <= 4'd0;
      err_q <= 1'b0;
    end else begin
      rc_q  <= rc_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic         out_valid_q, out_valid_d;
  logic [0:127] out_data_q,  out_data_d;
  logic         out_last_q,  out_last_d;
  logic [3:0]   out_idx_q,   out_idx_d;

  assign out_valid = out_valid_q;
  assign state_out = out_data_q;
  assign out_last  = out_last_q;
  assign round_idx = out_idx_q;

`ifdef SKID_BUF_EN
  // --------------------------------------------------------------------------
  // Skid-buffered build: in_ready is a flop, so a beat may arrive in the same
  // cycle the output stalls; the skid entry absorbs that one beat.
  // --------------------------------------------------------------------------
  logic         skid_full_q, skid_full_d;
  logic [0:127] skid_data_q, skid_data_d;
  logic         skid_last_q, skid_last_d;
  logic [3:0]   skid_idx_q,  skid_idx_d;
  logic         in_ready_q,  in_ready_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_idx_d  = skid_idx_q;
    if (!out_valid_q || out_ready) begin
      if (skid_full_q) begin
        // Older skid beat goes first to keep order; in_ready is low while
        // the skid is full, so no new beat competes here.
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        out_idx_d   = skid_idx_q;
        skid_full_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = w_beat_data;
        out_last_d  = in_last;
        out_idx_d   = w_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_full_d = 1'b1;
      skid_data_d = w_beat_data;
      skid_last_d = in_last;
      skid_idx_d  = w_tag;
    end
    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 4'd0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_idx_q  <= 4'd0;
      in_ready_q  <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_idx_q  <= skid_idx_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // The reset gate keeps the stage closed during the reset cycle itself.
  assign in_ready = in_ready_q && !rst;

`else
  // --------------------------------------------------------------------------
  // Single-register build: the stage can take a beat whenever the output is
  // empty or being drained in the same cycle.
  // --------------------------------------------------------------------------
  assign in_ready = !rst && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    if (!out_valid_q || out_ready) begin
      if (w_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = w_beat_data;
        out_last_d  = in_last;
        out_idx_d   = w_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end
`endif

endmodule
`default_nettype wire
